// File: rtl/coord_scan_seq.sv
// Coordinate ROM scan sequencer: walks coord_rom addresses 0..NUM_POINTS-1 and
// streams (x, z, index) beats through a 2-entry credit-managed output buffer.
module coord_scan_seq #(
  parameter int WIDTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int NUM_POINTS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WIDTH-1:0]  rom_x,
  input  logic [WIDTH-1:0]  rom_z,
  output logic [WIDTH-1:0]  px_x,
  output logic [WIDTH-1:0]  px_z,
  output logic [ADDR_W-1:0] px_index,
  output logic              px_last,
  output logic              px_valid,
  input  logic              px_ready
);

  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(NUM_POINTS - 1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_POINTS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W:0]   issue_cnt_r;
  logic [ADDR_W-1:0] rom_addr_r;
  logic              inflight_r;
  logic [ADDR_W-1:0] inflight_idx_r;
  logic              busy_r, done_r;

  logic [1:0]        occ_r, occ_s;
  logic [WIDTH-1:0]  head_x_r, head_z_r, head_x_s, head_z_s;
  logic [ADDR_W-1:0] head_idx_r, head_idx_s;
  logic [WIDTH-1:0]  skid_x_r, skid_z_r, skid_x_s, skid_z_s;
  logic [ADDR_W-1:0] skid_idx_r, skid_idx_s;
  logic              valid_r, valid_s, last_r, last_s;

  logic              issue_s, pop_s, push_s;
  logic [2:0]        credit_s, limit_s;

  // The ROM return is owned by the in-flight flag, so a push is exactly one cycle after an issue.
  assign pop_s    = valid_r & px_ready;
  assign push_s   = inflight_r;
  assign credit_s = {1'b0, occ_r} + {2'b00, inflight_r} + 3'd1;
  assign limit_s  = 3'd2 + {2'b00, pop_s};

  // Next-state and issue decision.
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (credit_s <= limit_s) begin
          issue_s = 1'b1;
          if (issue_cnt_r == LAST_CNT) begin
            state_s = DRAIN;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        // Leave as the last beat handshakes so done follows that edge directly.
        if (!inflight_r && ((occ_r == 2'd0) || ((occ_r == 2'd1) && pop_s))) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output buffer next values: head feeds the beat outputs, skid holds the second entry.
  always_comb begin
    occ_s      = occ_r;
    head_x_s   = head_x_r;
    head_z_s   = head_z_r;
    head_idx_s = head_idx_r;
    skid_x_s   = skid_x_r;
    skid_z_s   = skid_z_r;
    skid_idx_s = skid_idx_r;
    case ({push_s, pop_s})
      2'b10: begin
        occ_s = occ_r + 2'd1;
        if (occ_r == 2'd0) begin
          head_x_s   = rom_x;
          head_z_s   = rom_z;
          head_idx_s = inflight_idx_r;
        end else begin
          skid_x_s   = rom_x;
          skid_z_s   = rom_z;
          skid_idx_s = inflight_idx_r;
        end
      end
      2'b01: begin
        occ_s = occ_r - 2'd1;
        if (occ_r == 2'd2) begin
          head_x_s   = skid_x_r;
          head_z_s   = skid_z_r;
          head_idx_s = skid_idx_r;
        end else begin
          head_idx_s = head_idx_r;
        end
      end
      2'b11: begin
        if (occ_r == 2'd2) begin
          head_x_s   = skid_x_r;
          head_z_s   = skid_z_r;
          head_idx_s = skid_idx_r;
          skid_x_s   = rom_x;
          skid_z_s   = rom_z;
          skid_idx_s = inflight_idx_r;
        end else begin
          head_x_s   = rom_x;
          head_z_s   = rom_z;
          head_idx_s = inflight_idx_r;
        end
      end
      default: begin
        occ_s = occ_r;
      end
    endcase
    valid_s = (occ_s != 2'd0);
    last_s  = valid_s && (head_idx_s == LAST_IDX);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Address issue, return ownership and status flags; termination counts issues, never rom_addr.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_r    <= '0;
      rom_addr_r     <= '0;
      inflight_r     <= 1'b0;
      inflight_idx_r <= '0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      if ((state_r == IDLE) && start) begin
        issue_cnt_r <= '0;
        rom_addr_r  <= '0;
      end else if (issue_s) begin
        issue_cnt_r <= issue_cnt_r + CNT_ONE;
        rom_addr_r  <= issue_cnt_r[ADDR_W-1:0];
      end
      inflight_r <= issue_s;
      if (issue_s) begin
        inflight_idx_r <= issue_cnt_r[ADDR_W-1:0];
      end
      busy_r <= (state_s == RUN) || (state_s == DRAIN);
      done_r <= (state_s == DONE);
    end
  end

  // Output buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r      <= 2'd0;
      head_x_r   <= '0;
      head_z_r   <= '0;
      head_idx_r <= '0;
      skid_x_r   <= '0;
      skid_z_r   <= '0;
      skid_idx_r <= '0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
    end else begin
      occ_r      <= occ_s;
      head_x_r   <= head_x_s;
      head_z_r   <= head_z_s;
      head_idx_r <= head_idx_s;
      skid_x_r   <= skid_x_s;
      skid_z_r   <= skid_z_s;
      skid_idx_r <= skid_idx_s;
      valid_r    <= valid_s;
      last_r     <= last_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign rom_addr = rom_addr_r;
  assign px_x     = head_x_r;
  assign px_z     = head_z_r;
  assign px_index = head_idx_r;
  assign px_last  = last_r;
  assign px_valid = valid_r;

endmodule

// File: tb/tb_coord_scan_seq.sv
// Randomized bench for coord_scan_seq: a queue of expected beats built from the scan
// rules is drained on every handshake; timing, hold and credit rules checked per cycle.
module tb_coord_scan_seq;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 4;
  localparam int NP     = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [WIDTH-1:0]  x;
    logic [WIDTH-1:0]  z;
    logic              last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, busy, done, px_last, px_valid, px_ready;
  logic [ADDR_W-1:0] rom_addr, px_index;
  logic [WIDTH-1:0]  rom_x, rom_z, px_x, px_z;

  logic              start_1, busy_1, done_1, px_last_1, px_valid_1, px_ready_1;
  logic [ADDR_W-1:0] rom_addr_1, px_index_1;
  logic [WIDTH-1:0]  rom_x_1, rom_z_1, px_x_1, px_z_1;

  logic [WIDTH-1:0]  rom_x_mem [2**ADDR_W];
  logic [WIDTH-1:0]  rom_z_mem [2**ADDR_W];

  // coord_rom stand-in: data for rom_addr is available to the sequencer on the next edge
  assign rom_x   = rom_x_mem[rom_addr];
  assign rom_z   = rom_z_mem[rom_addr];
  assign rom_x_1 = rom_x_mem[rom_addr_1];
  assign rom_z_1 = rom_z_mem[rom_addr_1];

  coord_scan_seq #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NUM_POINTS(NP)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_x(rom_x), .rom_z(rom_z),
    .px_x(px_x), .px_z(px_z), .px_index(px_index), .px_last(px_last),
    .px_valid(px_valid), .px_ready(px_ready)
  );

  coord_scan_seq #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NUM_POINTS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_1), .busy(busy_1), .done(done_1),
    .rom_addr(rom_addr_1), .rom_x(rom_x_1), .rom_z(rom_z_1),
    .px_x(px_x_1), .px_z(px_z_1), .px_index(px_index_1), .px_last(px_last_1),
    .px_valid(px_valid_1), .px_ready(px_ready_1)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs_main();
    return 64'({busy, done, px_valid, px_last, px_x, px_z, px_index, rom_addr});
  endfunction

  function automatic logic [63:0] outs_one();
    return 64'({busy_1, done_1, px_valid_1, px_last_1, px_x_1, px_z_1, px_index_1, rom_addr_1});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 ready always, 1 ready 1,0,0,1 pattern, 2 stall 20 cycles, 3 random ready
  task automatic run_scan(input int mode, input bit poke, input int abort_at);
    int k, first_k, done_k, done_cnt, accepted, tail;
    bit rdy, stall;
    beat_t e;
    logic [37:0] held;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      rom_x_mem[i] = WIDTH'($urandom);
      rom_z_mem[i] = WIDTH'($urandom);
    end
    exp_q.delete();
    for (int i = 0; i < NP; i++) begin
      e.idx  = ADDR_W'(i);
      e.x    = rom_x_mem[i];
      e.z    = rom_z_mem[i];
      e.last = (i == NP - 1);
      exp_q.push_back(e);
    end
    first_k = -1; done_k = -1; done_cnt = 0; accepted = 0; tail = 0; k = 0;
    start = 1'b1; px_ready = 1'b0;
    tick();
    start = 1'b0;
    check_eq("busy_after_start", 64'(busy), 64'd1);
    check_eq("addr_after_start", 64'(rom_addr), 64'd0);
    while (k < 400 && tail < 4 && !(abort_at > 0 && accepted == abort_at)) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ((k % 4) == 0) || ((k % 4) == 3);
        2: rdy = (k >= 20);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      px_ready = rdy;
      start = poke && (k == 5);
      stall = px_valid && !rdy;
      held = {px_valid, px_last, px_index, px_x, px_z};
      if (px_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check_eq("beat_count", 64'(accepted + 1), 64'(NP));
        end else begin
          e = exp_q.pop_front();
          check_eq("beat_index", 64'(px_index), 64'(e.idx));
          check_eq("beat_x", 64'(px_x), 64'(e.x));
          check_eq("beat_z", 64'(px_z), 64'(e.z));
          check_eq("beat_last", 64'(px_last), 64'(e.last));
          if (mode == 0) check_eq("beat_time", 64'(k + 1), 64'(int'(e.idx) + 3));
        end
        accepted++;
      end
      tick();
      k++;
      if (stall) check_eq("stall_hold", 64'({px_valid, px_last, px_index, px_x, px_z}), 64'(held));
      check_eq("addr_lead", 64'(int'(rom_addr) <= accepted + 1), 64'd1);
      if (px_valid && first_k < 0) first_k = k;
      if (done) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k;
          check_eq("busy_at_done", 64'(busy), 64'd0);
          check_eq("done_after_last", 64'(accepted), 64'(NP));
        end
      end
      if (done_k >= 0) tail++;
      if (mode == 2 && k == 20) begin
        check_eq("stall_addr", 64'(rom_addr), 64'd1);
        check_eq("stall_index", 64'(px_index), 64'd0);
        check_eq("stall_valid", 64'(px_valid), 64'd1);
      end
    end
    px_ready = 1'b0;
    start = 1'b0;
    if (abort_at > 0) begin
      check_eq("abort_reached", 64'(accepted), 64'(abort_at));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("reset_midscan", outs_main(), 64'd0);
      for (int i = 0; i < 5; i++) begin
        tick();
        check_eq("after_abort_idle", outs_main(), 64'd0);
      end
      check_eq("abort_no_done", 64'(done_cnt), 64'd0);
    end else begin
      check_eq("scan_finished", 64'(done_k >= 0), 64'd1);
      check_eq("done_count", 64'(done_cnt), 64'd1);
      check_eq("beats_left", 64'(exp_q.size()), 64'd0);
      check_eq("beats_accepted", 64'(accepted), 64'(NP));
      if (mode == 0) begin
        check_eq("first_valid_cycle", 64'(first_k), 64'd2);
        check_eq("done_cycle", 64'(done_k), 64'(NP + 2));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) begin
      rom_x_mem[i] = WIDTH'($urandom);
      rom_z_mem[i] = WIDTH'($urandom);
    end
    rst = 1'b1; start = 1'b0; px_ready = 1'b0; start_1 = 1'b0; px_ready_1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle_outputs", outs_main(), 64'd0);
      check_eq("idle_outputs_np1", outs_one(), 64'd0);
    end

    run_scan(0, 1'b0, 0);
    run_scan(1, 1'b0, 0);
    run_scan(2, 1'b0, 0);
    run_scan(3, 1'b1, 0);

    // single-point scan
    start_1 = 1'b1; px_ready_1 = 1'b1;
    tick();
    start_1 = 1'b0;
    check_eq("np1_busy", 64'(busy_1), 64'd1);
    tick();
    check_eq("np1_not_yet_valid", 64'(px_valid_1), 64'd0);
    tick();
    check_eq("np1_beat", 64'({px_valid_1, px_last_1, px_index_1}), 64'({1'b1, 1'b1, 4'd0}));
    check_eq("np1_x", 64'(px_x_1), 64'(rom_x_mem[0]));
    check_eq("np1_z", 64'(px_z_1), 64'(rom_z_mem[0]));
    tick();
    check_eq("np1_done", 64'({done_1, busy_1, px_valid_1}), 64'({1'b1, 1'b0, 1'b0}));
    tick();
    check_eq("np1_done_pulse", 64'(done_1), 64'd0);
    px_ready_1 = 1'b0;

    run_scan(0, 1'b0, 6);
    run_scan(3, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
